// File: rtl/counter_seq.sv
// Command-driven sequencer for a WIDTH-bit up-counter: accepts run commands over valid/ready,
// counts 0..limit at a prescaled rate, one-shot (done pulse) or continuous (wrap pulse).
module counter_seq #(
    parameter int unsigned WIDTH      = 5,
    parameter int unsigned PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [WIDTH-1:0]      cmd_limit,
    input  logic [PRESCALE_W-1:0] cmd_prescale,
    input  logic                  cmd_mode,
    input  logic                  pause,
    input  logic                  abort,
    output logic [WIDTH-1:0]      count,
    output logic                  busy,
    output logic                  done,
    output logic                  wrap
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [WIDTH-1:0]      count_q, count_d;
    logic [WIDTH-1:0]      limit_q, limit_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [PRESCALE_W-1:0] presc_cnt_q, presc_cnt_d;
    logic                  mode_q, mode_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  wrap_q, wrap_d;
    logic                  tick;
    logic                  terminal;

    // A tick is one prescaled step; pause suppresses it and freezes the prescaler.
    assign tick     = (state_q == StRun) && !pause && (presc_cnt_q == presc_q);
    assign terminal = (count_q == limit_q);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        limit_d     = limit_q;
        presc_d     = presc_q;
        presc_cnt_d = presc_cnt_q;
        mode_d      = mode_q;
        done_d      = 1'b0;
        wrap_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    limit_d     = cmd_limit;
                    presc_d     = cmd_prescale;
                    mode_d      = cmd_mode;
                    count_d     = '0;
                    presc_cnt_d = '0;
                    state_d     = StRun;
                end
            end
            StRun: begin
                if (abort) begin
                    count_d     = '0;
                    presc_cnt_d = '0;
                    state_d     = StIdle;
                end else if (pause) begin
                    count_d     = count_q;
                    presc_cnt_d = presc_cnt_q;
                end else if (tick) begin
                    presc_cnt_d = '0;
                    if (terminal) begin
                        count_d = '0;
                        if (mode_q) begin
                            wrap_d = 1'b1;
                        end else begin
                            done_d  = 1'b1;
                            state_d = StDone;
                        end
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end else begin
                    presc_cnt_d = presc_cnt_q + 1'b1;
                end
            end
            StDone: begin
                count_d = '0;
                state_d = StIdle;
            end
            default: begin
                count_d     = '0;
                presc_cnt_d = '0;
                state_d     = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            count_q     <= '0;
            limit_q     <= '0;
            presc_q     <= '0;
            presc_cnt_q <= '0;
            mode_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            limit_q     <= limit_d;
            presc_q     <= presc_d;
            presc_cnt_q <= presc_cnt_d;
            mode_q      <= mode_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            wrap_q      <= wrap_d;
        end
    end

    assign cmd_ready = (state_q == StIdle);
    assign count     = count_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_counter_seq.sv
// Self-checking bench for counter_seq: directed scenarios plus random stimulus, all checked
// against a model that derives count from elapsed unpaused cycles.
module tb_counter_seq;

    logic       clk;
    logic       reset_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [4:0] cmd_limit;
    logic [7:0] cmd_prescale;
    logic       cmd_mode;
    logic       pause;
    logic       abort;
    logic [4:0] count;
    logic       busy;
    logic       done;
    logic       wrap;

    counter_seq #(
        .WIDTH      (5),
        .PRESCALE_W (8)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_limit    (cmd_limit),
        .cmd_prescale (cmd_prescale),
        .cmd_mode     (cmd_mode),
        .pause        (pause),
        .abort        (abort),
        .count        (count),
        .busy         (busy),
        .done         (done),
        .wrap         (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: phase 0 idle, 1 running, 2 done cycle. Count is derived from the number of
    // unpaused run cycles since the handshake: ticks = n / (P+1), count = ticks mod (L+1).
    int m_ph = 0;
    int m_L, m_P, m_mode, m_n;
    int e_count = 0;
    int e_done  = 0;
    int e_wrap  = 0;

    task automatic model_step();
        int t;
        e_done = 0;
        e_wrap = 0;
        if (!reset_n) begin
            m_ph    = 0;
            e_count = 0;
        end else if (m_ph == 0) begin
            if (cmd_valid) begin
                m_L     = int'(cmd_limit);
                m_P     = int'(cmd_prescale);
                m_mode  = int'(cmd_mode);
                m_n     = 0;
                m_ph    = 1;
                e_count = 0;
            end
        end else if (m_ph == 1) begin
            if (abort) begin
                m_ph    = 0;
                e_count = 0;
            end else if (!pause) begin
                m_n++;
                if (m_n % (m_P + 1) == 0) begin
                    t       = m_n / (m_P + 1);
                    e_count = t % (m_L + 1);
                    if (e_count == 0) begin
                        if (m_mode != 0) begin
                            e_wrap = 1;
                        end else begin
                            e_done = 1;
                            m_ph   = 2;
                        end
                    end
                end
            end
        end else begin
            m_ph = 0;
        end
    endtask

    function automatic logic [8:0] obs();
        return {count, busy, done, wrap, cmd_ready};
    endfunction

    function automatic logic [8:0] expv();
        return {e_count[4:0], (m_ph != 0), e_done[0], e_wrap[0], (m_ph == 0)};
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic start(input int lim, input int pre, input int mode);
        cmd_limit    = lim[4:0];
        cmd_prescale = pre[7:0];
        cmd_mode     = mode[0];
        cmd_valid    = 1'b1;
        cycle();
        cmd_valid    = 1'b0;
        // Later changes to the command fields must not disturb the run.
        cmd_limit    = 5'($urandom);
        cmd_prescale = 8'($urandom);
        cmd_mode     = 1'($urandom);
    endtask

    task automatic test_reset();
        logic [8:0] rst_v;
        rst_v     = {5'd0, 4'b0001};
        reset_n   = 1'b0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            n_checks++;
            if (obs() !== rst_v) begin
                n_fail++;
                $display("FAIL reset_init[%0d]: got %b want %b", i, obs(), rst_v);
            end
        end
        reset_n   = 1'b1;
        cmd_valid = 1'b0;
        cycle();
        n_checks++;
        if (obs() !== rst_v) begin
            n_fail++;
            $display("FAIL reset_no_accept: got %b want %b", obs(), rst_v);
        end
        // Reset in the middle of a run.
        start(10, 0, 0);
        repeat (4) cycle();
        n_checks++;
        if (count !== 5'd4) begin
            n_fail++;
            $display("FAIL reset_pre_count: got %0d want 4", count);
        end
        reset_n   = 1'b0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            n_checks++;
            if (obs() !== rst_v) begin
                n_fail++;
                $display("FAIL reset_midrun[%0d]: got %b want %b", i, obs(), rst_v);
            end
        end
        reset_n   = 1'b1;
        cmd_valid = 1'b0;
        cycle();
        n_checks++;
        if (obs() !== expv()) begin
            n_fail++;
            $display("FAIL reset_after: got %b want %b", obs(), expv());
        end
    endtask

    task automatic test_oneshot();
        logic [8:0] tab [6];
        tab = '{{5'd0, 4'b1000}, {5'd1, 4'b1000}, {5'd2, 4'b1000}, {5'd3, 4'b1000},
                {5'd0, 4'b1100}, {5'd0, 4'b0001}};
        start(3, 0, 0);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) cycle();
            n_checks++;
            if (obs() !== tab[k]) begin
                n_fail++;
                $display("FAIL oneshot_E%0d: got %b want %b", k, obs(), tab[k]);
            end
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL oneshot_model_E%0d: got %b want %b", k, obs(), expv());
            end
        end
    endtask

    task automatic test_prescale();
        logic [8:0] tab [8];
        tab = '{{5'd0, 4'b1000}, {5'd0, 4'b1000}, {5'd0, 4'b1000}, {5'd1, 4'b1000},
                {5'd1, 4'b1000}, {5'd1, 4'b1000}, {5'd0, 4'b1100}, {5'd0, 4'b0001}};
        start(1, 2, 0);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) cycle();
            n_checks++;
            if (obs() !== tab[k]) begin
                n_fail++;
                $display("FAIL prescale_E%0d: got %b want %b", k, obs(), tab[k]);
            end
        end
    endtask

    task automatic test_continuous();
        int wraps;
        wraps = 0;
        start(31, 0, 1);
        cmd_valid = 1'b1;
        cmd_limit = 5'd2;
        for (int k = 0; k < 100; k++) begin
            cycle();
            if (wrap === 1'b1) wraps++;
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL cont_model_%0d: got %b want %b", k, obs(), expv());
            end
        end
        n_checks++;
        if (wraps != 3) begin
            n_fail++;
            $display("FAIL cont_wraps: got %0d want 3", wraps);
        end
        cmd_valid = 1'b0;
        abort     = 1'b1;
        cycle();
        abort = 1'b0;
        n_checks++;
        if (obs() !== {5'd0, 4'b0001}) begin
            n_fail++;
            $display("FAIL cont_abort: got %b want %b", obs(), {5'd0, 4'b0001});
        end
    endtask

    task automatic test_pause_abort();
        int done_at;
        logic [8:0] idle_v;
        idle_v  = {5'd0, 4'b0001};
        done_at = -1;
        start(5, 0, 0);
        repeat (2) cycle();
        pause = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            n_checks++;
            if (count !== 5'd2) begin
                n_fail++;
                $display("FAIL pause_hold_%0d: got %0d want 2", k, count);
            end
        end
        pause = 1'b0;
        cycle();
        n_checks++;
        if (count !== 5'd3) begin
            n_fail++;
            $display("FAIL pause_resume: got %0d want 3", count);
        end
        for (int k = 7; k < 20 && done_at < 0; k++) begin
            cycle();
            if (done === 1'b1) done_at = k;
        end
        n_checks++;
        if (done_at != 9) begin
            n_fail++;
            $display("FAIL pause_done_edge: got %0d want 9", done_at);
        end
        cycle();
        // Abort at count 4.
        start(5, 0, 0);
        repeat (4) cycle();
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        n_checks++;
        if (obs() !== idle_v) begin
            n_fail++;
            $display("FAIL abort_idle: got %b want %b", obs(), idle_v);
        end
        for (int k = 0; k < 3; k++) begin
            cycle();
            n_checks++;
            if (obs() !== idle_v) begin
                n_fail++;
                $display("FAIL abort_quiet_%0d: got %b want %b", k, obs(), idle_v);
            end
        end
        // Abort and pause together.
        start(5, 0, 0);
        repeat (2) cycle();
        abort = 1'b1;
        pause = 1'b1;
        cycle();
        abort = 1'b0;
        pause = 1'b0;
        n_checks++;
        if (obs() !== idle_v) begin
            n_fail++;
            $display("FAIL abort_pause: got %b want %b", obs(), idle_v);
        end
    endtask

    task automatic test_edge_limit0();
        start(0, 0, 0);
        cycle();
        n_checks++;
        if (obs() !== {5'd0, 4'b1100}) begin
            n_fail++;
            $display("FAIL l0_done: got %b want %b", obs(), {5'd0, 4'b1100});
        end
        cycle();
        n_checks++;
        if (obs() !== {5'd0, 4'b0001}) begin
            n_fail++;
            $display("FAIL l0_ready: got %b want %b", obs(), {5'd0, 4'b0001});
        end
        start(0, 0, 1);
        for (int k = 0; k < 5; k++) begin
            cycle();
            n_checks++;
            if (obs() !== {5'd0, 4'b1010}) begin
                n_fail++;
                $display("FAIL l0_wrap_%0d: got %b want %b", k, obs(), {5'd0, 4'b1010});
            end
        end
        abort = 1'b1;
        cycle();
        abort = 1'b0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            cmd_valid    = ($urandom_range(0, 99) < 30);
            cmd_limit    = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            cmd_prescale = 8'($urandom_range(0, 3));
            cmd_mode     = 1'($urandom);
            pause        = ($urandom_range(0, 99) < 20);
            abort        = ($urandom_range(0, 99) < 3);
            reset_n      = ($urandom_range(0, 199) != 0);
            cycle();
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL random_%0d: got %b want %b", k, obs(), expv());
            end
        end
        cmd_valid = 1'b0;
        pause     = 1'b0;
        abort     = 1'b0;
        reset_n   = 1'b1;
    endtask

    initial begin
        reset_n      = 1'b0;
        cmd_valid    = 1'b0;
        cmd_limit    = '0;
        cmd_prescale = '0;
        cmd_mode     = 1'b0;
        pause        = 1'b0;
        abort        = 1'b0;
        test_reset();
        test_oneshot();
        test_prescale();
        test_continuous();
        test_pause_abort();
        test_edge_limit0();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
